// File: rtl/hybrid_search_master_pkg.sv
// Shared types for the hybrid_search initiator: query modes, response status and FSM states.
package hybrid_search_pkg;

  localparam logic [1:0] MODE_SOUL   = 2'd0;
  localparam logic [1:0] MODE_FLOW   = 2'd1;
  localparam logic [1:0] MODE_REFLEX = 2'd2;
  localparam logic [1:0] MODE_BAD    = 2'd3;

  typedef enum logic [1:0] {
    STAT_HIT     = 2'd0,
    STAT_MISS    = 2'd1,
    STAT_TIMEOUT = 2'd2,
    STAT_BADMODE = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_STREAM = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_e;

endpackage

// File: rtl/hs_cand_pick.sv
// Priority pick of the lowest-index valid flow candidate out of four 16-bit IDs.
module hs_cand_pick (
  input  logic [3:0]  valid_i,
  input  logic [63:0] cand_id_i,
  output logic [15:0] id_o,
  output logic        any_o
);

  always_comb begin
    id_o = '0;
    for (int i = 3; i >= 0; i--) begin
      if (valid_i[i]) id_o = cand_id_i[i*16 +: 16];
    end
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/hybrid_search_master.sv
// Initiator for hybrid_search: issues one soul/flow/reflex query at a time and condenses the result.
// Optional HYBRID_SEARCH_MASTER_LATENCY_EN adds resp_latency_o (accept-to-result cycles, saturating).
//
// state  | meaning
// IDLE   | ready for a request
// RD     | soul: read HV chunk group g from the buffer
// STREAM | soul: capture group g, then offer it as a query
// ISSUE  | flow/reflex: query offered
// WAIT   | waiting for a matching result or timeout
// RESP   | response held until taken
module hybrid_search_master
  import hybrid_search_pkg::*;
#(
  parameter int TAG_W          = 8,
  parameter int CHUNK_W        = 2048,
  parameter int N_GROUPS       = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SOUL_MIN_SCORE = 8192
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [1:0]                  req_mode_i,
  input  logic [TAG_W-1:0]            req_tag_i,
  input  logic [63:0]                 req_sig_i,
  input  logic [55:0]                 req_key_i,
  output logic                        hv_rd_en_o,
  output logic [$clog2(N_GROUPS)-1:0] hv_rd_group_o,
  input  logic [CHUNK_W-1:0]          hv_rd_data_i,
  output logic [1:0]                  hs_mode_select_o,
  output logic                        hs_query_valid_o,
  input  logic                        hs_query_ready_i,
  output logic [CHUNK_W-1:0]          hs_soul_chunks_o,
  output logic [$clog2(N_GROUPS)-1:0] hs_soul_chunk_idx_o,
  output logic [63:0]                 hs_flow_sig_o,
  output logic [55:0]                 hs_reflex_key_o,
  input  logic                        hs_result_valid_i,
  input  logic [1:0]                  hs_result_mode_i,
  input  logic [10:0]                 hs_soul_top_idx0_i,
  input  logic [14:0]                 hs_soul_top_score0_i,
  input  logic [63:0]                 hs_flow_cand_id_i,
  input  logic [3:0]                  hs_flow_cand_valid_i,
  input  logic                        hs_reflex_matched_i,
  input  logic [7:0]                  hs_reflex_action_i,
  input  logic [7:0]                  hs_reflex_rule_id_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic [TAG_W-1:0]            resp_tag_o,
  output logic [1:0]                  resp_mode_o,
  output logic [1:0]                  resp_status_o,
  output logic [15:0]                 resp_id_o,
  output logic [15:0]                 resp_aux_o,
  output logic                        busy_o,
  output logic [15:0]                 timeout_count_o
`ifdef HYBRID_SEARCH_MASTER_LATENCY_EN
  ,
  output logic [15:0]                 resp_latency_o
`endif
);

  localparam int GW = $clog2(N_GROUPS);
  localparam logic [GW-1:0] G_LAST = GW'(N_GROUPS - 1);
  localparam logic [31:0]   T_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [1:0]           mode_q;
  logic [TAG_W-1:0]     tag_q;
  logic [63:0]          sig_q;
  logic [55:0]          key_q;
  logic [GW-1:0]        g_q;
  logic                 first_q;
  logic [CHUNK_W-1:0]   chunk_q;
  logic [31:0]          cnt_q;
  status_e              status_q;
  logic [15:0]          id_q, aux_q, tcnt_q;
  logic                 q_hs, res_match, tmo_hit, soul_hit, flow_any;
  logic [15:0]          flow_id;

  hs_cand_pick u_cand_pick (
    .valid_i   (hs_flow_cand_valid_i),
    .cand_id_i (hs_flow_cand_id_i),
    .id_o      (flow_id),
    .any_o     (flow_any)
  );

  assign q_hs      = hs_query_valid_o && hs_query_ready_i;
  assign res_match = (state_q == S_WAIT) && hs_result_valid_i && (hs_result_mode_i == mode_q);
  assign tmo_hit   = (state_q == S_WAIT) && (cnt_q == T_LAST);
  assign soul_hit  = 32'(hs_soul_top_score0_i) >= 32'(SOUL_MIN_SCORE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_valid_i) begin
        if (req_mode_i == MODE_SOUL)     state_d = S_RD;
        else if (req_mode_i == MODE_BAD) state_d = S_RESP;
        else                             state_d = S_ISSUE;
      end
      S_RD:     state_d = S_STREAM;
      S_STREAM: if (q_hs) state_d = (g_q == G_LAST) ? S_WAIT : S_RD;
      S_ISSUE:  if (hs_query_ready_i) state_d = S_WAIT;
      S_WAIT:   if (res_match || tmo_hit) state_d = S_RESP;
      S_RESP:   if (resp_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o      = (state_q == S_IDLE);
    hv_rd_en_o       = (state_q == S_RD);
    hv_rd_group_o    = (state_q == S_RD) ? g_q : '0;
    hs_query_valid_o = ((state_q == S_STREAM) && !first_q) || (state_q == S_ISSUE);
    hs_mode_select_o = (state_q inside {S_RD, S_STREAM, S_ISSUE, S_WAIT}) ? mode_q : 2'd0;
    resp_valid_o     = (state_q == S_RESP);
    busy_o           = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      tag_q    <= '0;
      sig_q    <= '0;
      key_q    <= '0;
      g_q      <= '0;
      first_q  <= 1'b0;
      chunk_q  <= '0;
      cnt_q    <= '0;
      status_q <= STAT_HIT;
      id_q     <= '0;
      aux_q    <= '0;
      tcnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (req_valid_i) begin
          mode_q <= req_mode_i;
          tag_q  <= req_tag_i;
          sig_q  <= req_sig_i;
          key_q  <= req_key_i;
          g_q    <= '0;
          if (req_mode_i == MODE_BAD) begin
            status_q <= STAT_BADMODE;
            id_q     <= '0;
            aux_q    <= '0;
          end
        end
        S_RD: first_q <= 1'b1;
        // hv_rd_data is valid exactly during the first STREAM cycle
        S_STREAM: begin
          if (first_q) begin
            chunk_q <= hv_rd_data_i;
            first_q <= 1'b0;
          end else if (q_hs && (g_q != G_LAST)) begin
            g_q <= g_q + GW'(1);
          end
        end
        S_WAIT: begin
          if (res_match) begin
            unique case (mode_q)
              MODE_SOUL: begin
                status_q <= soul_hit ? STAT_HIT : STAT_MISS;
                id_q     <= {5'd0, hs_soul_top_idx0_i};
                aux_q    <= {1'b0, hs_soul_top_score0_i};
              end
              MODE_FLOW: begin
                status_q <= flow_any ? STAT_HIT : STAT_MISS;
                id_q     <= flow_id;
                aux_q    <= {12'd0, hs_flow_cand_valid_i};
              end
              default: begin
                status_q <= hs_reflex_matched_i ? STAT_HIT : STAT_MISS;
                id_q     <= {8'd0, hs_reflex_rule_id_i};
                aux_q    <= {8'd0, hs_reflex_action_i};
              end
            endcase
          end else if (tmo_hit) begin
            status_q <= STAT_TIMEOUT;
            id_q     <= '0;
            aux_q    <= '0;
            if (tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
          end
        end
        default: ;
      endcase
      cnt_q <= (state_q == S_WAIT) ? cnt_q + 32'd1 : 32'd0;
    end
  end

  assign hs_soul_chunks_o    = chunk_q;
  assign hs_soul_chunk_idx_o = g_q;
  assign hs_flow_sig_o       = sig_q;
  assign hs_reflex_key_o     = key_q;
  assign resp_tag_o          = tag_q;
  assign resp_mode_o         = mode_q;
  assign resp_status_o       = status_q;
  assign resp_id_o           = id_q;
  assign resp_aux_o          = aux_q;
  assign timeout_count_o     = tcnt_q;

`ifdef HYBRID_SEARCH_MASTER_LATENCY_EN
  logic [15:0] lat_q;

  // Counts up to and including the cycle the result/timeout is taken, then holds through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q <= '0;
    end else if ((state_q == S_IDLE) && req_valid_i) begin
      lat_q <= (req_mode_i == MODE_BAD) ? 16'd0 : 16'd1;
    end else if (((state_q inside {S_RD, S_STREAM, S_ISSUE}) ||
                  ((state_q == S_WAIT) && !res_match && !tmo_hit)) && (lat_q != 16'hFFFF)) begin
      lat_q <= lat_q + 16'd1;
    end
  end

  assign resp_latency_o = lat_q;
`endif

endmodule

// File: tb/tb_hybrid_search_master.sv
// Directed bench for hybrid_search_master with a spec-level response model and per-cycle compare.
module tb_hybrid_search_master;

  localparam int TAG_W          = 8;
  localparam int CHUNK_W        = 2048;
  localparam int N_GROUPS       = 8;
  localparam int TIMEOUT_CYCLES = 4096;
  localparam int SOUL_MIN_SCORE = 8192;

  logic               clk, rst_n;
  logic               req_valid, req_ready;
  logic [1:0]         req_mode;
  logic [TAG_W-1:0]   req_tag;
  logic [63:0]        req_sig;
  logic [55:0]        req_key;
  logic               hv_rd_en;
  logic [2:0]         hv_rd_group;
  logic [CHUNK_W-1:0] hv_rd_data;
  logic [1:0]         hs_mode_select;
  logic               hs_query_valid, hs_query_ready;
  logic [CHUNK_W-1:0] hs_soul_chunks;
  logic [2:0]         hs_soul_chunk_idx;
  logic [63:0]        hs_flow_sig;
  logic [55:0]        hs_reflex_key;
  logic               hs_result_valid;
  logic [1:0]         hs_result_mode;
  logic [10:0]        hs_soul_top_idx0;
  logic [14:0]        hs_soul_top_score0;
  logic [63:0]        hs_flow_cand_id;
  logic [3:0]         hs_flow_cand_valid;
  logic               hs_reflex_matched;
  logic [7:0]         hs_reflex_action, hs_reflex_rule_id;
  logic               resp_valid, resp_ready;
  logic [TAG_W-1:0]   resp_tag;
  logic [1:0]         resp_mode, resp_status;
  logic [15:0]        resp_id, resp_aux;
  logic               busy;
  logic [15:0]        timeout_count;

  hybrid_search_master #(
    .TAG_W(TAG_W), .CHUNK_W(CHUNK_W), .N_GROUPS(N_GROUPS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SOUL_MIN_SCORE(SOUL_MIN_SCORE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_mode_i(req_mode),
    .req_tag_i(req_tag), .req_sig_i(req_sig), .req_key_i(req_key),
    .hv_rd_en_o(hv_rd_en), .hv_rd_group_o(hv_rd_group), .hv_rd_data_i(hv_rd_data),
    .hs_mode_select_o(hs_mode_select), .hs_query_valid_o(hs_query_valid),
    .hs_query_ready_i(hs_query_ready), .hs_soul_chunks_o(hs_soul_chunks),
    .hs_soul_chunk_idx_o(hs_soul_chunk_idx), .hs_flow_sig_o(hs_flow_sig),
    .hs_reflex_key_o(hs_reflex_key), .hs_result_valid_i(hs_result_valid),
    .hs_result_mode_i(hs_result_mode), .hs_soul_top_idx0_i(hs_soul_top_idx0),
    .hs_soul_top_score0_i(hs_soul_top_score0), .hs_flow_cand_id_i(hs_flow_cand_id),
    .hs_flow_cand_valid_i(hs_flow_cand_valid), .hs_reflex_matched_i(hs_reflex_matched),
    .hs_reflex_action_i(hs_reflex_action), .hs_reflex_rule_id_i(hs_reflex_rule_id),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_tag_o(resp_tag),
    .resp_mode_o(resp_mode), .resp_status_o(resp_status), .resp_id_o(resp_id),
    .resp_aux_o(resp_aux), .busy_o(busy), .timeout_count_o(timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected state of the current query (written by stimulus, read by the compare process)
  logic [1:0]       exp_mode;
  logic [TAG_W-1:0] exp_tag;
  logic [63:0]      exp_sig;
  logic [55:0]      exp_key;
  logic [1:0]       exp_status;
  logic [15:0]      exp_id, exp_aux;
  int               exp_group;
  logic             no_query;

  function automatic logic [CHUNK_W-1:0] pat(input int g);
    logic [7:0] b;
    b = 8'(8'hA0 + g);
    return {256{b}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Result condensing rules applied to a result the model has decided is accepted
  task automatic expect_result(input logic [10:0] idx, input logic [14:0] score,
                               input logic [63:0] cids, input logic [3:0] cv,
                               input logic matched, input logic [7:0] act, input logic [7:0] rule);
    if (exp_mode == 2'd0) begin
      exp_status = (int'(score) >= SOUL_MIN_SCORE) ? 2'd0 : 2'd1;
      exp_id     = 16'(idx);
      exp_aux    = 16'(score);
    end else if (exp_mode == 2'd1) begin
      exp_status = 2'd1;
      exp_id     = 16'd0;
      for (int i = 0; i < 4; i++) begin
        if (cv[i] && exp_status == 2'd1) begin
          exp_id     = cids[i*16 +: 16];
          exp_status = 2'd0;
        end
      end
      exp_aux = 16'(cv);
    end else begin
      exp_status = matched ? 2'd0 : 2'd1;
      exp_id     = 16'(rule);
      exp_aux    = 16'(act);
    end
  endtask

  // HV buffer: data for a read appears the cycle after the strobe, garbage otherwise
  logic       rd_pend = 1'b0;
  logic [2:0] rd_grp  = 3'd0;
  always @(negedge clk) begin
    hv_rd_data = rd_pend ? pat(int'(rd_grp)) : {CHUNK_W{1'b1}};
    rd_pend    = hv_rd_en;
    rd_grp     = hv_rd_group;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        chk("resp_tag",    64'(resp_tag),    64'(exp_tag));
        chk("resp_mode",   64'(resp_mode),   64'(exp_mode));
        chk("resp_status", 64'(resp_status), 64'(exp_status));
        chk("resp_id",     64'(resp_id),     64'(exp_id));
        chk("resp_aux",    64'(resp_aux),    64'(exp_aux));
      end
      if (hs_query_valid) begin
        chk("query_mode_select", 64'(hs_mode_select), 64'(exp_mode));
        if (exp_mode == 2'd0) begin
          chk("soul_chunk_idx", 64'(hs_soul_chunk_idx), 64'(exp_group));
          chk("soul_chunk_data", 64'(hs_soul_chunks == pat(exp_group)), 64'd1);
          if (hs_query_ready) exp_group++;
        end else if (exp_mode == 2'd1) begin
          chk("flow_sig", hs_flow_sig, exp_sig);
        end else begin
          chk("reflex_key", 64'(hs_reflex_key), 64'(exp_key));
        end
      end
      if (no_query) chk("badmode_no_query", 64'(hs_query_valid), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [1:0] mode, input logic [7:0] tag,
                          input logic [63:0] sig, input logic [55:0] key);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("req_ready_before_req", 64'(req_ready), 64'd1);
    exp_mode = mode; exp_tag = tag; exp_sig = sig; exp_key = key; exp_group = 0;
    req_valid = 1'b1; req_mode = mode; req_tag = tag; req_sig = sig; req_key = key;
    tick();
    req_valid = 1'b0;
  endtask

  // Flow/reflex: query must be up the cycle after accept; take it immediately
  task automatic issue_hs();
    chk("issue_latency", 64'(hs_query_valid), 64'd1);
    hs_query_ready = 1'b1;
    tick();
    hs_query_ready = 1'b0;
  endtask

  task automatic stream_soul(input int stall_group, input int stall_n);
    int st = 0;
    int n = 0;
    while (exp_group < N_GROUPS && n < 200) begin
      hs_query_ready = !(hs_query_valid && int'(hs_soul_chunk_idx) == stall_group && st < stall_n);
      if (!hs_query_ready) st++;
      tick(); n++;
    end
    hs_query_ready = 1'b0;
    chk("soul_groups_issued", 64'(exp_group), 64'(N_GROUPS));
    chk("soul_stall_cycles", 64'(st), 64'(stall_n));
  endtask

  task automatic send_result(input int j, input logic [1:0] rmode, input logic [10:0] idx,
                             input logic [14:0] score, input logic [63:0] cids, input logic [3:0] cv,
                             input logic matched, input logic [7:0] act, input logic [7:0] rule);
    repeat (j) tick();
    if (rmode == exp_mode) expect_result(idx, score, cids, cv, matched, act, rule);
    hs_result_valid = 1'b1; hs_result_mode = rmode; hs_soul_top_idx0 = idx;
    hs_soul_top_score0 = score; hs_flow_cand_id = cids; hs_flow_cand_valid = cv;
    hs_reflex_matched = matched; hs_reflex_action = act; hs_reflex_rule_id = rule;
    tick();
    hs_result_valid = 1'b0;
  endtask

  task automatic wait_resp(input int bound, output int n);
    n = 0;
    while (!resp_valid && n < bound) begin tick(); n++; end
    chk("resp_arrived", 64'(resp_valid), 64'd1);
  endtask

  task automatic finish_resp(input int hold);
    repeat (hold) begin
      chk("req_ready_in_resp", 64'(req_ready), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("idle_after_resp", 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; no_query = 1'b0;
    req_valid = 0; req_mode = 0; req_tag = 0; req_sig = 0; req_key = 0;
    hs_query_ready = 0; hs_result_valid = 0; hs_result_mode = 0;
    hs_soul_top_idx0 = 0; hs_soul_top_score0 = 0; hs_flow_cand_id = 0; hs_flow_cand_valid = 0;
    hs_reflex_matched = 0; hs_reflex_action = 0; hs_reflex_rule_id = 0; resp_ready = 0;
    exp_mode = 0; exp_tag = 0; exp_sig = 0; exp_key = 0;
    exp_status = 0; exp_id = 0; exp_aux = 0; exp_group = 0;
    repeat (3) tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_query_valid", 64'(hs_query_valid), 64'd0);
    chk("rst_mode_select", 64'(hs_mode_select), 64'd0);
    chk("rst_timeout_count", 64'(timeout_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // Reflex hit two cycles after issue
    send_req(2'd2, 8'h11, 64'd0, 56'h12);
    issue_hs();
    send_result(2, 2'd2, 11'd0, 15'd0, 64'd0, 4'd0, 1'b1, 8'h03, 8'h05);
    wait_resp(10, n);
    chk("result_to_resp_latency", 64'(n), 64'd0);
    chk("reflex_status_lit", 64'(resp_status), 64'd0);
    chk("reflex_id_lit", 64'(resp_id), 64'd5);
    chk("reflex_aux_lit", 64'(resp_aux), 64'd3);
    chk("reflex_tag_lit", 64'(resp_tag), 64'h11);
    finish_resp(0);

    // Flow hit with a mismatched-mode result dropped first; response held 10 cycles
    send_req(2'd1, 8'h22, 64'hDEAD_BEEF_0123_4567, 56'd0);
    issue_hs();
    send_result(0, 2'd2, 11'd0, 15'd0, 64'd0, 4'd0, 1'b1, 8'h77, 8'h09);
    chk("mismatch_ignored", 64'(resp_valid), 64'd0);
    send_result(1, 2'd1, 11'd0, 15'd0, {16'h4444, 16'h0ABC, 16'h2222, 16'h3333}, 4'b0100,
                1'b0, 8'd0, 8'd0);
    wait_resp(10, n);
    chk("flow_id_lit", 64'(resp_id), 64'h0ABC);
    chk("flow_aux_lit", 64'(resp_aux), 64'h0004);
    finish_resp(10);

    // Flow miss
    send_req(2'd1, 8'h23, 64'h0000_0000_0000_00F0, 56'd0);
    issue_hs();
    send_result(0, 2'd1, 11'd0, 15'd0, 64'h1234_5678_9ABC_DEF0, 4'b0000, 1'b0, 8'd0, 8'd0);
    wait_resp(10, n);
    chk("flow_miss_lit", 64'(resp_status), 64'd1);
    finish_resp(0);

    // Soul hit with a 3-cycle stall on group 4
    send_req(2'd0, 8'h33, 64'd0, 56'd0);
    stream_soul(4, 3);
    send_result(3, 2'd0, 11'h123, 15'd9000, 64'd0, 4'd0, 1'b0, 8'd0, 8'd0);
    wait_resp(10, n);
    chk("soul_hit_status_lit", 64'(resp_status), 64'd0);
    chk("soul_hit_aux_lit", 64'(resp_aux), 64'd9000);
    finish_resp(2);

    // Soul miss
    send_req(2'd0, 8'h34, 64'd0, 56'd0);
    stream_soul(-1, 0);
    send_result(0, 2'd0, 11'h7FF, 15'd100, 64'd0, 4'd0, 1'b0, 8'd0, 8'd0);
    wait_resp(10, n);
    chk("soul_miss_status_lit", 64'(resp_status), 64'd1);
    finish_resp(0);

    // Timeout: no result at all
    send_req(2'd1, 8'h45, 64'h55, 56'd0);
    issue_hs();
    exp_status = 2'd2; exp_id = 16'd0; exp_aux = 16'd0;
    wait_resp(TIMEOUT_CYCLES + 20, n);
    chk("timeout_latency", 64'(n), 64'(TIMEOUT_CYCLES));
    chk("timeout_count_one", 64'(timeout_count), 64'd1);
    finish_resp(0);

    // Result on the last WAIT cycle beats the timeout
    send_req(2'd1, 8'h46, 64'h56, 56'd0);
    issue_hs();
    send_result(TIMEOUT_CYCLES - 1, 2'd1, 11'd0, 15'd0, 64'h0000_0000_0000_0055, 4'b0001,
                1'b0, 8'd0, 8'd0);
    wait_resp(5, n);
    chk("late_result_wins_lit", 64'(resp_status), 64'd0);
    chk("timeout_count_kept", 64'(timeout_count), 64'd1);
    finish_resp(0);

    // Invalid mode: immediate BADMODE, search interface untouched
    no_query = 1'b1;
    send_req(2'd3, 8'h47, 64'd0, 56'd0);
    exp_status = 2'd3; exp_id = 16'd0; exp_aux = 16'd0;
    wait_resp(5, n);
    chk("badmode_within_2", 64'(n <= 1), 64'd1);
    chk("badmode_mode_select", 64'(hs_mode_select), 64'd0);
    finish_resp(1);
    no_query = 1'b0;

    // Async reset in the middle of a soul stream
    send_req(2'd0, 8'h58, 64'd0, 56'd0);
    n = 0;
    hs_query_ready = 1'b1;
    while (exp_group < 2 && n < 50) begin tick(); n++; end
    tick();
    rst_n = 1'b0;
    hs_query_ready = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_query_valid", 64'(hs_query_valid), 64'd0);
    chk("mid_rst_rd_en", 64'(hv_rd_en), 64'd0);
    chk("mid_rst_mode_select", 64'(hs_mode_select), 64'd0);
    chk("mid_rst_chunks_zero", 64'(hs_soul_chunks == '0), 64'd1);
    chk("mid_rst_chunk_idx", 64'(hs_soul_chunk_idx), 64'd0);
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_timeout_count", 64'(timeout_count), 64'd0);
    chk("mid_rst_resp_tag", 64'(resp_tag), 64'd0);
    tick();
    rst_n = 1'b1;
    exp_group = 0;
    tick();
    hs_result_valid = 1'b1; hs_result_mode = 2'd0;
    tick();
    hs_result_valid = 1'b0;
    tick();
    chk("late_result_after_rst_busy", 64'(busy), 64'd0);
    chk("late_result_after_rst_resp", 64'(resp_valid), 64'd0);

    // Operational again after reset: reflex miss
    send_req(2'd2, 8'h59, 64'd0, 56'h00_AB_CD_EF);
    issue_hs();
    send_result(1, 2'd2, 11'd0, 15'd0, 64'd0, 4'd0, 1'b0, 8'h07, 8'h02);
    wait_resp(10, n);
    chk("post_rst_reflex_miss_lit", 64'(resp_status), 64'd1);
    finish_resp(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
